uart_cmd_slave: RTL and testbench
=================================

Name: uart_cmd_slave

Overview:
- UART command responder: the far end of the command UART master.
- Receives command frames on rx and decodes write/read. Writes drive a register-bus strobe; reads fetch register data and return one frame on tx.
- Sits between the board-level rx/tx pins and the local register bank.
- Frame format: 1 start bit (0), 8 data bits LSB first, odd-parity bit equal to ~^data, 1 stop bit (1).

Parameters:
- BR, 434, clocks per bit (50 MHz / 115200); legal range 16..511.
- TURN, 100, idle clocks between the end of a read command and the response start bit; legal range 1..255.
- TIMEOUT, 8191, max clocks from a write command's stop sample to the data byte's start edge; legal range 1..8191.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- rx  in  1  serial in, asynchronous to clk
- tx  out  1  serial out, idle high
- reg_addr  out  7  register address
- reg_wdata  out  8  write data
- reg_we  out  1  write strobe, 1-cycle pulse
- reg_re  out  1  read strobe, 1-cycle pulse
- reg_rdata  in  8  read data, valid the cycle after reg_re
- busy  out  1  high whenever the command FSM is outside WAIT_CMD
- err  out  1  1-cycle pulse on parity, framing or timeout error

Behaviour:
- Reset (async, rst_n=0): tx=1, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, err=0. Both FSMs go to their idle states and all counters clear. Reset mid-frame aborts the frame with no strobe.
- rx passes through a 2-flop synchronizer before use. Start detect is a 1→0 transition on the synchronized rx.
- Byte receiver states:
  - R_IDLE: start detect → R_START.
  - R_START: bit counter runs to BR/2 (integer). If rx is still 0 there, restart the counter → R_DATA; otherwise it is a false start → R_IDLE with no error.
  - R_DATA: sample rx every BR clocks; 8 samples, LSB first → R_PAR.
  - R_PAR: sample after BR clocks → R_STOP.
  - R_STOP: sample after BR clocks, then → R_IDLE.
- Byte accept/reject: the byte is accepted (1-cycle byte_done internal pulse) only if parity == ~^data and stop == 1. Otherwise err pulses and the byte is discarded.
- Command FSM:
  - WAIT_CMD, on byte_done:
    - data[7]=1 (write): latch reg_addr=data[6:0] → WAIT_WDATA.
    - data[7]=0 (read): latch reg_addr → RD_REQ.
  - WAIT_WDATA:
    - byte_done: reg_wdata=data, reg_we=1 for exactly 1 cycle → WAIT_CMD.
    - Timeout counter exceeds TIMEOUT before a start edge: err pulse → WAIT_CMD, no write.
    - A receive error here: err pulse → WAIT_CMD.
  - RD_REQ: reg_re=1 for 1 cycle → RD_CAP.
  - RD_CAP: capture reg_rdata into the tx shift register → TX_GAP.
  - TX_GAP: tx=1 for TURN clocks → TX_START.
  - TX_START, TX_DATA (8 bits, LSB first), TX_PAR (~^ of the shifted byte), TX_STOP: each bit is held exactly BR clocks.
  - End of TX_STOP → WAIT_CMD.
- Read latency: read-command stop sample to response start-bit falling edge is exactly 2+TURN clocks.
- Half-duplex: the receiver is held in R_IDLE and ignores rx while the command FSM is in RD_REQ..TX_STOP. Bytes arriving then are lost with no error.
- The command FSM is driven only by byte_done, the timeout and receive-error events.
- tx is registered and glitch-free; tx=1 in every non-transmit state.
- reg_addr and reg_wdata hold their last value between commands.
- Counter widths: bit counter 9 bits, bit index 4 bits, gap counter 8 bits, timeout counter 13 bits; all saturate or clear, never wrap mid-frame.

Test Plan (BR=16, TURN=4, TIMEOUT=200 unless stated):
- Write: send 0x85 then 0x3C with correct parity → one reg_we pulse with reg_addr=0x05, reg_wdata=0x3C; err never asserted; busy low afterwards.
- Read: send 0x12 with reg_rdata=0xA7 presented the cycle after reg_re → single reg_re with reg_addr=0x12. tx start edge arrives exactly 6 clocks after the stop sample. Frame bits are 0, 1,1,1,0,0,1,0,1, parity 0, stop 1, each 16 clocks wide.
- Parity error: send 0x85 with the parity bit inverted → err pulse; no reg_we; FSM stays in WAIT_CMD. A following valid 0x81,0x55 writes 0x55 to addr 0x01.
- Framing/timeout: send 0x85 then stay idle for 250 clocks → err pulse at clock 201, no reg_we. Separately, send a frame with stop=0 → err pulse, byte dropped.
- False start: drive a 4-clock low glitch on rx → no byte_done, no err, receiver returns to idle.
- Reset mid-operation: assert rst_n=0 during TX_DATA of a read response → tx=1 immediately, busy=0. After release, a new 0x85/0x3C write completes normally.

Source files
------------

// File: rtl/uart_cmd_slave_if.sv
// Pin and register-bus bundle for the UART command responder.
// The slave modport is the responder's view; the master modport is the
// view of whatever sits around it (pins, register bank, or a bench).
interface uart_cmd_slave_if;
    logic       rx;
    logic       tx;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       err;

    modport slave (
        input  rx, reg_rdata,
        output tx, reg_addr, reg_wdata, reg_we, reg_re, busy, err
    );

    modport master (
        output rx, reg_rdata,
        input  tx, reg_addr, reg_wdata, reg_we, reg_re, busy, err
    );
endinterface

// File: rtl/uart_cmd_slave.sv
// UART command responder: decodes write (addr|0x80, data) and read (addr)
// command frames from rx, strobes the local register bus, and returns
// read data as one 8O1 frame on tx after a fixed turnaround gap.
module uart_cmd_slave #(
    parameter int BR      = 434,   // clocks per bit
    parameter int TURN    = 100,   // idle clocks before a read response
    parameter int TIMEOUT = 8191   // max wait for the write data byte
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_cmd_slave_if.slave   bus
);

    localparam logic [8:0]  BR_LAST   = 9'(BR - 1);
    localparam logic [8:0]  HALF_LAST = 9'(BR / 2 - 1);
    localparam logic [7:0]  GAP_LAST  = 8'(TURN - 1);
    localparam logic [12:0] TO_MAX    = 13'(TIMEOUT);

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_PAR, R_STOP
    } rx_state_t;

    typedef enum logic [3:0] {
        WAIT_CMD, WAIT_WDATA, RD_REQ, RD_CAP,
        TX_GAP, TX_START, TX_DATA, TX_PAR, TX_STOP
    } cmd_state_t;

    rx_state_t  rx_state;
    cmd_state_t cmd_state;

    logic       rx_meta, rx_sync, rx_prev;
    logic [8:0] rx_cnt;
    logic [3:0] rx_idx;
    logic [7:0] rx_shreg;
    logic       rx_par;
    logic       rx_hold;
    logic       byte_done, rx_err;

    logic [8:0]  tx_cnt;
    logic [3:0]  tx_idx;
    logic [7:0]  tx_shreg;
    logic        tx_par;
    logic [7:0]  gap_cnt;
    logic [12:0] to_cnt;

    // Two-flop synchronizer for rx plus one delayed copy for edge detect.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge value of its neighbours, exactly like real hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver is deaf while a read is being served (half-duplex).
    assign rx_hold = !(cmd_state == WAIT_CMD || cmd_state == WAIT_WDATA);

    // Stop-bit sample decides accept (byte_done) or reject (rx_err).
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        byte_done = 1'b0;
        rx_err    = 1'b0;
        if (rx_state == R_STOP && rx_cnt == BR_LAST) begin
            if (rx_sync && (rx_par == ~^rx_shreg)) byte_done = 1'b1;
            else                                   rx_err    = 1'b1;
        end
    end

    // Byte receiver: mid-bit sampling timed from the start-bit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shreg <= '0;
            rx_par   <= 1'b0;
        end else if (rx_hold) begin
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
        end else begin
            case (rx_state)
                R_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_sync) rx_state <= R_START;
                end
                R_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 9'd1;
                    end
                end
                R_DATA: begin
                    if (rx_cnt == BR_LAST) begin
                        rx_cnt   <= '0;
                        rx_shreg <= {rx_sync, rx_shreg[7:1]};
                        if (rx_idx == 4'd7) rx_state <= R_PAR;
                        else                rx_idx   <= rx_idx + 4'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 9'd1;
                    end
                end
                R_PAR: begin
                    if (rx_cnt == BR_LAST) begin
                        rx_cnt   <= '0;
                        rx_par   <= rx_sync;
                        rx_state <= R_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 9'd1;
                    end
                end
                R_STOP: begin
                    if (rx_cnt == BR_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= R_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 9'd1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Command FSM: decode, register strobes, timeout and read response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_state     <= WAIT_CMD;
            bus.tx        <= 1'b1;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
            bus.reg_we    <= 1'b0;
            bus.reg_re    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.err       <= 1'b0;
            tx_cnt        <= '0;
            tx_idx        <= '0;
            tx_shreg      <= '0;
            tx_par        <= 1'b0;
            gap_cnt       <= '0;
            to_cnt        <= '0;
        end else begin
            bus.reg_we <= 1'b0;
            bus.reg_re <= 1'b0;
            bus.err    <= rx_err;
            case (cmd_state)
                WAIT_CMD: begin
                    if (byte_done) begin
                        bus.reg_addr <= rx_shreg[6:0];
                        bus.busy     <= 1'b1;
                        to_cnt       <= '0;
                        if (rx_shreg[7]) begin
                            cmd_state <= WAIT_WDATA;
                        end else begin
                            bus.reg_re <= 1'b1;
                            cmd_state  <= RD_REQ;
                        end
                    end
                end
                WAIT_WDATA: begin
                    if (byte_done) begin
                        bus.reg_wdata <= rx_shreg;
                        bus.reg_we    <= 1'b1;
                        bus.busy      <= 1'b0;
                        cmd_state     <= WAIT_CMD;
                    end else if (rx_err) begin
                        bus.busy  <= 1'b0;
                        cmd_state <= WAIT_CMD;
                    end else if (rx_state == R_IDLE) begin
                        // Only idle line time counts; a start edge freezes it.
                        if (to_cnt == TO_MAX) begin
                            bus.err   <= 1'b1;
                            bus.busy  <= 1'b0;
                            cmd_state <= WAIT_CMD;
                        end else begin
                            to_cnt <= to_cnt + 13'd1;
                        end
                    end
                end
                RD_REQ: cmd_state <= RD_CAP;
                RD_CAP: begin
                    tx_shreg  <= bus.reg_rdata;
                    tx_par    <= ~^bus.reg_rdata;
                    gap_cnt   <= '0;
                    cmd_state <= TX_GAP;
                end
                TX_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        bus.tx    <= 1'b0;
                        tx_cnt    <= '0;
                        cmd_state <= TX_START;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BR_LAST) begin
                        bus.tx    <= tx_shreg[0];
                        tx_shreg  <= {1'b0, tx_shreg[7:1]};
                        tx_idx    <= '0;
                        tx_cnt    <= '0;
                        cmd_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 9'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BR_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == 4'd7) begin
                            bus.tx    <= tx_par;
                            cmd_state <= TX_PAR;
                        end else begin
                            bus.tx   <= tx_shreg[0];
                            tx_shreg <= {1'b0, tx_shreg[7:1]};
                            tx_idx   <= tx_idx + 4'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 9'd1;
                    end
                end
                TX_PAR: begin
                    if (tx_cnt == BR_LAST) begin
                        bus.tx    <= 1'b1;
                        tx_cnt    <= '0;
                        cmd_state <= TX_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + 9'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BR_LAST) begin
                        tx_cnt    <= '0;
                        bus.busy  <= 1'b0;
                        cmd_state <= WAIT_CMD;
                    end else begin
                        tx_cnt <= tx_cnt + 9'd1;
                    end
                end
                default: begin
                    bus.tx    <= 1'b1;
                    bus.busy  <= 1'b0;
                    cmd_state <= WAIT_CMD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Scoreboard bench for uart_cmd_slave: stimulus pushes expected register
// events and tx frames; independent monitors pop and compare them.
module tb_uart_cmd_slave;

    localparam int BR      = 16;
    localparam int TURN    = 4;
    localparam int TIMEOUT = 200;
    // Edge of the stop-bit sample, counted from the negedge the start bit
    // is driven: first edge + two synchronizer edges + half bit + ten bits.
    localparam int STOP_OFS = 1 + 2 + BR / 2 + 10 * BR;

    typedef enum int {EV_WR, EV_RD, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [6:0] addr;
        logic [7:0] data;
        int         at;
    } ev_t;
    typedef struct {
        logic [7:0] data;
        int         at;
    } tx_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    ev_t        ev_q[$];
    tx_exp_t    tx_q[$];
    bit         tx_active = 1'b0;
    bit         tx_ignore = 1'b0;
    logic [7:0] rd_value = 8'h00;
    logic       re_seen = 1'b0;

    uart_cmd_slave_if bus ();

    uart_cmd_slave #(.BR(BR), .TURN(TURN), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Register-bank model: read data appears the cycle after reg_re.
    initial begin
        bus.reg_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus.reg_rdata = re_seen ? rd_value : 8'h00;
            re_seen       = bus.reg_re;
        end
    end

    task automatic take(input ev_kind_t k, input logic [6:0] a, input logic [7:0] d);
        ev_t e;
        check("event_expected", 32'(ev_q.size() != 0), 32'd1);
        if (ev_q.size() != 0) begin
            e = ev_q.pop_front();
            check("event_kind", 32'(k), 32'(e.kind));
            if (k != EV_ERR) check("event_addr", 32'(a), 32'(e.addr));
            if (k == EV_WR)  check("event_wdata", 32'(d), 32'(e.data));
            check("event_cycle", 32'(cyc), 32'(e.at));
        end
    endtask

    // Register-bus and error monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.reg_we) take(EV_WR, bus.reg_addr, bus.reg_wdata);
            if (bus.reg_re) take(EV_RD, bus.reg_addr, 8'h00);
            if (bus.err)    take(EV_ERR, 7'h00, 8'h00);
        end
    end

    // tx frame monitor: start time, then every bit must hold BR samples.
    initial begin
        tx_exp_t     e;
        logic [10:0] f;
        int          good;
        forever begin
            @(negedge clk);
            if (rst_n && bus.tx === 1'b0) begin
                if (tx_ignore) begin
                    for (int i = 0; i < 4000 && rst_n; i++) @(negedge clk);
                end else begin
                    tx_active = 1'b1;
                    check("tx_frame_expected", 32'(tx_q.size() != 0), 32'd1);
                    if (tx_q.size() != 0) begin
                        e = tx_q.pop_front();
                        check("tx_start_cycle", 32'(cyc), 32'(e.at));
                        f = {1'b1, ~^e.data, e.data, 1'b0};
                        for (int b = 0; b < 11; b++) begin
                            good = 0;
                            for (int j = 0; j < BR; j++) begin
                                if (bus.tx === f[b]) good++;
                                @(negedge clk);
                            end
                            check($sformatf("tx_bit%0d_width", b), 32'(good), 32'(BR));
                        end
                    end
                    tx_active = 1'b0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit flip_par, input logic stop_val);
        logic [10:0] f;
        logic        par;
        par = (~^b) ^ flip_par;
        f   = {stop_val, par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            bus.rx = f[i];
            repeat (BR) @(negedge clk);
        end
        bus.rx = 1'b1;
    endtask

    task automatic push_ev(input ev_kind_t k, input logic [6:0] a, input logic [7:0] d, input int at);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        e.at   = at;
        ev_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && (ev_q.size() != 0 || tx_q.size() != 0 || tx_active); i++)
            @(negedge clk);
        check({"drain_", name}, 32'(ev_q.size() + tx_q.size() + int'(tx_active)), 32'd0);
        repeat (3) @(negedge clk);
        check({"busy_idle_", name}, 32'(bus.busy), 32'd0);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d, input string name);
        int c;
        send_byte({1'b1, a}, 1'b0, 1'b1);
        c = cyc;
        push_ev(EV_WR, a, d, c + STOP_OFS);
        send_byte(d, 1'b0, 1'b1);
        wait_drain(name, 500);
    endtask

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(bus.tx), 32'd1);
        check("rst_reg_addr", 32'(bus.reg_addr), 32'd0);
        check("rst_reg_wdata", 32'(bus.reg_wdata), 32'd0);
        check("rst_reg_we", 32'(bus.reg_we), 32'd0);
        check("rst_reg_re", 32'(bus.reg_re), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Write 0x3C to address 0x05.
        do_write(7'h05, 8'h3C, "write");
        check("hold_reg_addr", 32'(bus.reg_addr), 32'h05);
        check("hold_reg_wdata", 32'(bus.reg_wdata), 32'h3C);

        // Read address 0x12; response 0xA7 starts 2+TURN clocks after stop sample.
        rd_value = 8'hA7;
        c = cyc;
        push_ev(EV_RD, 7'h12, 8'h00, c + STOP_OFS);
        tx_q.push_back('{data: 8'hA7, at: c + STOP_OFS + 2 + TURN});
        send_byte(8'h12, 1'b0, 1'b1);
        check("busy_during_read", 32'(bus.busy), 32'd1);
        wait_drain("read", 600);

        // Parity error on a write command, then a clean write.
        c = cyc;
        push_ev(EV_ERR, 7'h00, 8'h00, c + STOP_OFS);
        send_byte(8'h85, 1'b1, 1'b1);
        wait_drain("parity", 100);
        do_write(7'h01, 8'h55, "after_parity");

        // Write command followed by silence: timeout error 201 clocks on.
        c = cyc;
        push_ev(EV_ERR, 7'h00, 8'h00, c + STOP_OFS + TIMEOUT + 1);
        send_byte(8'h85, 1'b0, 1'b1);
        repeat (250) @(negedge clk);
        wait_drain("timeout", 10);

        // Framing error: stop bit low, byte dropped.
        c = cyc;
        push_ev(EV_ERR, 7'h00, 8'h00, c + STOP_OFS);
        send_byte(8'h85, 1'b0, 1'b0);
        wait_drain("framing", 100);

        // False start: 4-clock glitch produces nothing.
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        bus.rx = 1'b1;
        repeat (40) @(negedge clk);
        wait_drain("false_start", 10);

        // Reset in the middle of a read response's data bits.
        rd_value  = 8'hA7;
        tx_ignore = 1'b1;
        c = cyc;
        push_ev(EV_RD, 7'h12, 8'h00, c + STOP_OFS);
        send_byte(8'h12, 1'b0, 1'b1);
        for (int i = 0; i < 50 && bus.tx !== 1'b0; i++) @(negedge clk);
        check("tx_start_seen", 32'(bus.tx), 32'd0);
        repeat (BR + 20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_tx", 32'(bus.tx), 32'd1);
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_reg_addr", 32'(bus.reg_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_ignore = 1'b0;
        repeat (5) @(negedge clk);
        check("midreset_queue", 32'(ev_q.size()), 32'd0);
        do_write(7'h05, 8'h3C, "after_reset");

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
